// File: rtl/alu_gen_pkg.sv
// Shared op codes and constants for the parametrised ALU.
// Reserved op codes are folded onto PASS before decoding.
package alu_gen_pkg;

    localparam int unsigned NIB_W = 4;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_ROL  = 4'h2;
    localparam logic [3:0] OP_ROR  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_PASS = 4'h7;
    localparam logic [3:0] OP_MUL  = 4'h8;

    function automatic logic [3:0] eff_op(input logic [3:0] op);
        return (op > OP_MUL) ? OP_PASS : op;
    endfunction

endpackage

// File: rtl/alu_gen_if.sv
// Request/result bundle between the operand latches and the ALU.
interface alu_gen_if #(
    parameter int unsigned W = 8
);
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] AI;
    logic [W-1:0] BI;
    logic         CI;
    logic         BCD;
    logic         busy;
    logic         done;
    logic [W-1:0] OUT;
    logic [W-1:0] OUT_HI;
    logic         CO;
    logic         V;
    logic         Z;
    logic         N;
    logic         HC;

    modport master (
        output start, op, AI, BI, CI, BCD,
        input  busy, done, OUT, OUT_HI, CO, V, Z, N, HC
    );

    modport slave (
        input  start, op, AI, BI, CI, BCD,
        output busy, done, OUT, OUT_HI, CO, V, Z, N, HC
    );
endinterface

// File: rtl/alu_bcd_nibble.sv
// One nibble of the add/subtract chain with optional decimal correction.
// b_i is already inverted for subtraction by the caller.
module alu_bcd_nibble (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    input  logic       sub_i,
    input  logic       bcd_i,
    output logic [3:0] r_o,
    output logic       cout_o
);
    logic [4:0] sum;

    assign sum = {1'b0, a_i} + {1'b0, b_i} + {4'b0, cin_i};

    always_comb begin
        r_o    = sum[3:0];
        cout_o = sum[4];
        if (bcd_i) begin
            if (!sub_i) begin
                if (sum > 5'd9) begin
                    r_o    = sum[3:0] + 4'd6;
                    cout_o = 1'b1;
                end else begin
                    cout_o = 1'b0;
                end
            end else if (!sum[4]) begin
                // no carry out of A+~B+cin means a borrow occurred
                r_o = sum[3:0] - 4'd6;
            end
        end
    end
endmodule

// File: rtl/alu_gen.sv
// Parametrised ALU: single-cycle arithmetic/logic/shift with optional decimal
// correction, plus a shift-add multiply taking W cycles. All state honours RDY.
module alu_gen
    import alu_gen_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input logic      clk,
    input logic      rst_n,
    input logic      RDY,
    alu_gen_if.slave bus
);
    localparam int unsigned NumNib = W / NIB_W;
    localparam int unsigned CntW   = $clog2(W + 1);

    typedef enum logic [0:0] {StIdle, StMul} state_e;
    state_e state_q, state_d;

    logic [3:0]      op_eff;
    logic            is_sub, accept, mul_last;
    logic [W-1:0]    b_p, arith, res;
    logic [NumNib:0] nc;
    logic [W:0]      bin, msum;
    logic            res_co, res_v, res_hc;
    logic [2*W-1:0]  prod_step;

    logic [W-1:0]    out_q, out_d, hi_q, hi_d, mcand_q, mcand_d;
    logic [2*W-1:0]  prod_q, prod_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            co_q, co_d, v_q, v_d, z_q, z_d, n_q, n_d, hc_q, hc_d;
    logic            done_q, done_d;

    assign op_eff   = eff_op(bus.op);
    assign is_sub   = (op_eff == OP_SUB);
    assign b_p      = is_sub ? ~bus.BI : bus.BI;
    assign bin      = {1'b0, bus.AI} + {1'b0, b_p} + {{W{1'b0}}, bus.CI};
    assign accept   = RDY & bus.start & (state_q == StIdle);
    assign mul_last = (state_q == StMul) & (cnt_q == CntW'(1));

    assign nc[0] = bus.CI;
    for (genvar i = 0; i < NumNib; i++) begin : g_nib
        alu_bcd_nibble u_nib (
            .a_i   (bus.AI[NIB_W*i +: NIB_W]),
            .b_i   (b_p[NIB_W*i +: NIB_W]),
            .cin_i (nc[i]),
            .sub_i (is_sub),
            .bcd_i (bus.BCD),
            .r_o   (arith[NIB_W*i +: NIB_W]),
            .cout_o(nc[i+1])
        );
    end

    always_comb begin
        res    = bus.AI;
        res_co = bus.CI;
        res_v  = 1'b0;
        res_hc = 1'b0;
        case (op_eff)
            OP_ADD, OP_SUB: begin
                res    = bus.BCD ? arith : bin[W-1:0];
                res_co = bus.BCD ? nc[NumNib] : bin[W];
                // overflow always judged on the binary sum, even in decimal mode
                res_v  = (bus.AI[W-1] == b_p[W-1]) & (bin[W-1] != bus.AI[W-1]);
                res_hc = nc[1];
            end
            OP_ROL: begin
                res    = {bus.AI[W-2:0], bus.CI};
                res_co = bus.AI[W-1];
            end
            OP_ROR: begin
                res    = {bus.CI, bus.AI[W-1:1]};
                res_co = bus.AI[0];
            end
            OP_OR:   res = bus.AI | bus.BI;
            OP_AND:  res = bus.AI & bus.BI;
            OP_XOR:  res = bus.AI ^ bus.BI;
            default: ;
        endcase
    end

    // Multiplier sits in the low half and shifts out as the product shifts in.
    assign msum      = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_step = {msum, prod_q[W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept && op_eff == OP_MUL) state_d = StMul;
            StMul:   if (RDY && mul_last)            state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy   = (state_q == StMul);
        bus.done   = done_q;
        bus.OUT    = out_q;
        bus.OUT_HI = hi_q;
        bus.CO     = co_q;
        bus.V      = v_q;
        bus.Z      = z_q;
        bus.N      = n_q;
        bus.HC     = hc_q;
    end

    always_comb begin
        out_d   = out_q;
        hi_d    = hi_q;
        co_d    = co_q;
        v_d     = v_q;
        z_d     = z_q;
        n_d     = n_q;
        hc_d    = hc_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        if (RDY) begin
            done_d = 1'b0;
            if (accept) begin
                if (op_eff == OP_MUL) begin
                    prod_d  = {{W{1'b0}}, bus.BI};
                    mcand_d = bus.AI;
                    cnt_d   = CntW'(W);
                end else begin
                    out_d  = res;
                    hi_d   = '0;
                    co_d   = res_co;
                    v_d    = res_v;
                    hc_d   = res_hc;
                    z_d    = (res == '0);
                    n_d    = res[W-1];
                    done_d = 1'b1;
                end
            end else if (state_q == StMul) begin
                prod_d = prod_step;
                cnt_d  = cnt_q - CntW'(1);
                if (mul_last) begin
                    out_d  = prod_step[W-1:0];
                    hi_d   = prod_step[2*W-1:W];
                    co_d   = 1'b0;
                    hc_d   = 1'b0;
                    v_d    = (prod_step[2*W-1:W] != '0);
                    n_d    = prod_step[2*W-1];
                    z_d    = (prod_step == '0);
                    done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            hi_q    <= '0;
            co_q    <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            hc_q    <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
        end else begin
            out_q   <= out_d;
            hi_q    <= hi_d;
            co_q    <= co_d;
            v_q     <= v_d;
            z_q     <= z_d;
            n_q     <= n_d;
            hc_q    <= hc_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
        end
    end
endmodule

// File: tb/tb_alu_gen.sv
// Self-checking bench for alu_gen (W=8): directed cases plus random ops
// checked against an arithmetic reference model.
module tb_alu_gen;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic RDY;

    alu_gen_if #(.W(W)) bus ();

    alu_gen #(.W(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .RDY  (RDY),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [20:0] last_exp;

    // {OUT, OUT_HI, CO, V, Z, N, HC}
    function automatic logic [20:0] model(input int op, input int a, input int b,
                                          input int ci, input int bcd);
        int r, hi, co, v, hc, z, n, s, sa, sb, da, db;
        r = a; hi = 0; co = ci; v = 0; hc = 0;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        da = (a >> 4) * 10 + (a & 15);
        db = (b >> 4) * 10 + (b & 15);
        case (op)
            0: begin
                s  = sa + sb + ci;
                v  = (s > 127 || s < -128) ? 1 : 0;
                if (bcd != 0) begin
                    s  = da + db + ci;
                    co = (s > 99) ? 1 : 0;
                    s  = s % 100;
                    r  = ((s / 10) << 4) | (s % 10);
                    hc = ((a & 15) + (b & 15) + ci > 9) ? 1 : 0;
                end else begin
                    s  = a + b + ci;
                    r  = s & 255;
                    co = (s > 255) ? 1 : 0;
                    hc = ((a & 15) + (b & 15) + ci > 15) ? 1 : 0;
                end
            end
            1: begin
                s  = sa - sb - 1 + ci;
                v  = (s > 127 || s < -128) ? 1 : 0;
                hc = ((a & 15) - (b & 15) - 1 + ci >= 0) ? 1 : 0;
                if (bcd != 0) begin
                    s  = da - db - 1 + ci;
                    co = (s >= 0) ? 1 : 0;
                    if (s < 0) s = s + 100;
                    r  = ((s / 10) << 4) | (s % 10);
                end else begin
                    s  = a - b - 1 + ci;
                    co = (s >= 0) ? 1 : 0;
                    r  = s & 255;
                end
            end
            2: begin r = ((a << 1) | ci) & 255; co = a >> 7; end
            3: begin r = (ci << 7) | (a >> 1);  co = a & 1;  end
            4: r = a | b;
            5: r = a & b;
            6: r = a ^ b;
            8: begin
                s  = a * b;
                r  = s & 255;
                hi = s >> 8;
                co = 0;
                v  = (hi != 0) ? 1 : 0;
            end
            default: r = a;
        endcase
        if (op == 8) begin
            n = hi >> 7;
            z = (r == 0 && hi == 0) ? 1 : 0;
        end else begin
            n = r >> 7;
            z = (r == 0) ? 1 : 0;
        end
        return {r[7:0], hi[7:0], co[0], v[0], z[0], n[0], hc[0]};
    endfunction

    function automatic logic [20:0] dut_vec();
        return {bus.OUT, bus.OUT_HI, bus.CO, bus.V, bus.Z, bus.N, bus.HC};
    endfunction

    task automatic apply(input int op, input int a, input int b, input int ci, input int bcd);
        bus.op    = op[3:0];
        bus.AI    = a[7:0];
        bus.BI    = b[7:0];
        bus.CI    = ci[0];
        bus.BCD   = bcd[0];
        bus.start = 1'b1;
    endtask

    task automatic test_reset();
        RDY = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({dut_vec(), bus.busy, bus.done} !== 23'h0) begin
            bad++;
            $display("FAIL reset: got %h busy=%b done=%b, want all zero",
                     dut_vec(), bus.busy, bus.done);
        end
        @(negedge clk) rst_n = 1'b1;
        last_exp = '0;
    endtask

    task automatic test_add_overflow();
        @(negedge clk) apply(0, 'h7F, 'h01, 0, 0);
        @(posedge clk) #1;
        bus.start = 1'b0;
        total++;
        if ({bus.done, bus.OUT, bus.V, bus.N, bus.CO, bus.Z} !== {1'b1, 8'h80, 4'b1100}) begin
            bad++;
            $display("FAIL add_7f_01: got done=%b out=%h v=%b n=%b co=%b z=%b, want 1 80 1 1 0 0",
                     bus.done, bus.OUT, bus.V, bus.N, bus.CO, bus.Z);
        end
        last_exp = model(0, 'h7F, 'h01, 0, 0);
        @(posedge clk) #1;
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL add_done_pulse: got done=%b, want 0", bus.done);
        end
    endtask

    task automatic test_bcd();
        int op[3]       = '{0, 1, 1};
        int a[3]        = '{'h58, 'h46, 'h12};
        int b[3]        = '{'h46, 'h12, 'h21};
        logic [8:0] w[3] = '{{8'h05, 1'b1}, {8'h34, 1'b1}, {8'h91, 1'b0}};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) apply(op[i], a[i], b[i], 1, 1);
            @(posedge clk) #1;
            bus.start = 1'b0;
            total++;
            if ({bus.OUT, bus.CO} !== w[i] || (i == 0 && bus.HC !== 1'b1)) begin
                bad++;
                $display("FAIL bcd_%0d: got out=%h co=%b hc=%b, want out=%h co=%b",
                         i, bus.OUT, bus.CO, bus.HC, w[i][8:1], w[i][0]);
            end
            last_exp = model(op[i], a[i], b[i], 1, 1);
            total++;
            if (dut_vec() !== last_exp) begin
                bad++;
                $display("FAIL bcd_model_%0d: got %h want %h", i, dut_vec(), last_exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int op, a, b, ci, bcd;
        for (int i = 0; i < 300; i++) begin
            op  = $urandom_range(0, 15);
            if (op == 8) op = 9 + $urandom_range(0, 6);
            bcd = $urandom_range(0, 1);
            ci  = $urandom_range(0, 1);
            if (bcd != 0 && op < 2) begin
                a = ($urandom_range(0, 9) << 4) | $urandom_range(0, 9);
                b = ($urandom_range(0, 9) << 4) | $urandom_range(0, 9);
            end else begin
                a = $urandom_range(0, 255);
                b = $urandom_range(0, 255);
            end
            @(negedge clk) apply(op, a, b, ci, bcd);
            @(posedge clk) #1;
            last_exp = model(op, a, b, ci, bcd);
            total++;
            if ({bus.done, dut_vec()} !== {1'b1, last_exp}) begin
                bad++;
                $display("FAIL b2b op=%0d a=%h b=%h ci=%0d bcd=%0d: got done=%b %h want 1 %h",
                         op, a, b, ci, bcd, bus.done, dut_vec(), last_exp);
            end
        end
        bus.start = 1'b0;
        @(posedge clk) #1;
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done_drop: got done=%b want 0", bus.done);
        end
    endtask

    task automatic test_mul_busy();
        logic [20:0] e;
        @(negedge clk) apply(8, 'hFF, 'hFF, 0, 0);
        @(posedge clk) #1;
        apply(0, 1, 1, 0, 0);  // held through the busy window, must be ignored
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(posedge clk) #1;
            total++;
            if ({bus.busy, bus.done, dut_vec()} !== {2'b10, last_exp}) begin
                bad++;
                $display("FAIL mul_busy_c%0d: got busy=%b done=%b %h want 1 0 %h",
                         c, bus.busy, bus.done, dut_vec(), last_exp);
            end
        end
        @(posedge clk) #1;
        bus.start = 1'b0;
        e = model(8, 'hFF, 'hFF, 0, 0);
        total++;
        if ({bus.busy, bus.done, dut_vec()} !== {2'b01, e} ||
            {bus.OUT_HI, bus.OUT, bus.V} !== {8'hFE, 8'h01, 1'b1}) begin
            bad++;
            $display("FAIL mul_ff: got busy=%b done=%b %h want 0 1 %h",
                     bus.busy, bus.done, dut_vec(), e);
        end
        last_exp = e;
        @(posedge clk) #1;
        total++;
        if ({bus.done, dut_vec()} !== {1'b0, last_exp}) begin
            bad++;
            $display("FAIL mul_ignored_start: got done=%b %h want 0 %h",
                     bus.done, dut_vec(), last_exp);
        end
    endtask

    task automatic test_mul_rdy();
        int dc = 0;
        @(negedge clk) apply(8, 'h0C, 'h0A, 0, 0);
        @(posedge clk) #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk) RDY = !(c >= 4 && c <= 6);
            @(posedge clk) #1;
            if (bus.done === 1'b1) begin
                dc = c;
                break;
            end
        end
        RDY = 1'b1;
        last_exp = model(8, 'h0C, 'h0A, 0, 0);
        total++;
        if (dc != 11 || dut_vec() !== last_exp || {bus.OUT_HI, bus.OUT} !== 16'h0078) begin
            bad++;
            $display("FAIL mul_rdy: got done at +%0d %h, want +11 %h", dc, dut_vec(), last_exp);
        end
        @(negedge clk) RDY = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk) #1;
            total++;
            if (bus.done !== 1'b1) begin
                bad++;
                $display("FAIL done_stretch_%0d: got done=%b want 1", c, bus.done);
            end
        end
        @(negedge clk) RDY = 1'b1;
        @(posedge clk) #1;
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL done_release: got done=%b want 0", bus.done);
        end
    endtask

    task automatic test_mul_random();
        int a, b, dc;
        for (int i = 0; i < 15; i++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            if (i == 0) b = 0;
            @(negedge clk) apply(8, a, b, $urandom_range(0, 1), 0);
            @(posedge clk) #1;
            bus.start = 1'b0;
            dc = 0;
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk) #1;
                if (bus.done === 1'b1) begin
                    dc = c;
                    break;
                end
            end
            last_exp = model(8, a, b, 0, 0);
            total++;
            if (dc != 8 || dut_vec() !== last_exp) begin
                bad++;
                $display("FAIL mul_rand %h*%h: got done at +%0d %h, want +8 %h",
                         a, b, dc, dut_vec(), last_exp);
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        int seen = 0;
        @(negedge clk) apply(8, 'h37, 'h5B, 0, 0);
        @(posedge clk) #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        total++;
        if ({dut_vec(), bus.busy, bus.done} !== 23'h0) begin
            bad++;
            $display("FAIL reset_mid_mul: got %h busy=%b done=%b, want all zero",
                     dut_vec(), bus.busy, bus.done);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk) #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL mul_abort: got %0d cycles with done/busy set, want 0", seen);
        end
    endtask

    task automatic test_ror_reserved();
        logic [20:0] e;
        @(negedge clk) apply(3, 'h01, 'h00, 1, 0);
        @(posedge clk) #1;
        bus.start = 1'b0;
        e = model(3, 'h01, 'h00, 1, 0);
        total++;
        if ({bus.OUT, bus.CO, bus.N} !== {8'h80, 2'b11} || dut_vec() !== e) begin
            bad++;
            $display("FAIL ror: got %h want %h (out=80 co=1 n=1)", dut_vec(), e);
        end
        @(negedge clk) apply('hB, 'h5A, 'hC3, 1, 0);
        @(posedge clk) #1;
        bus.start = 1'b0;
        e = model('hB, 'h5A, 'hC3, 1, 0);
        total++;
        if (bus.OUT !== 8'h5A || dut_vec() !== e) begin
            bad++;
            $display("FAIL reserved_op: got %h want %h", dut_vec(), e);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = '0;
        bus.AI    = '0;
        bus.BI    = '0;
        bus.CI    = 1'b0;
        bus.BCD   = 1'b0;
        test_reset();
        test_add_overflow();
        test_bcd();
        test_back_to_back();
        test_mul_busy();
        test_mul_rdy();
        test_mul_random();
        test_reset_mid_mul();
        test_ror_reserved();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_gen.md
# alu_gen

Parametrised successor to the 6502-style CPU ALU. It adds a configurable data width and full decimal correction for both add and subtract, and replaces the implicit single-cycle contract with a start/busy/done handshake. It also adds a multi-cycle unsigned multiply. It sits in the CPU datapath behind the operand latches and honours the global `RDY` stall, so it can also serve as a coprocessor for the game logic.

## Interface
- `W`, 8, data width; multiple of 4, minimum 4.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `RDY`  in  1  global enable; when low, every register holds.
- `start`  in  1  request; accepted on a rising edge when `RDY & !busy`.
- `op`  in  4  operation code, sampled at accept.
- `AI`  in  W  operand A, sampled at accept.
- `BI`  in  W  operand B, sampled at accept.
- `CI`  in  1  carry / shift-in, sampled at accept.
- `BCD`  in  1  decimal mode for ADD/SUB, sampled at accept.
- `busy`  out  1  multiply in progress.
- `done`  out  1  one-cycle pulse: result valid.
- `OUT`  out  W  result, low half for MUL.
- `OUT_HI`  out  W  MUL high half; 0 for other ops.
- `CO, V, Z, N, HC`  out  1 each  registered flags.

## Operation
- Op codes:
  - 0000 ADD: A+B+CI.
  - 0001 SUB: A+~B+CI (CI=1 means no borrow).
  - 0010 ROL: {A,CI} left, CO=A[W-1].
  - 0011 ROR: {CI,A} right, CO=A[0].
  - 0100 OR; 0101 AND; 0110 XOR; 0111 PASS A.
  - 1000 MUL: unsigned.
  - 1001–1111: reserved, behave as PASS A.
- ADD/SUB binary:
  - V = (A[W-1]==B'[W-1]) & (R[W-1]!=A[W-1]), where B'=B for ADD and ~B for SUB.
  - HC = carry out of bit 3.
- ADD/SUB with BCD=1, W/4 nibbles processed LSB first, carry rippled:
  - ADD: nibble sum >9 or nibble carry → +6, carry out 1.
  - SUB: nibble borrow → −6, carry out 0.
  - CO = final decimal carry (SUB: 1 = no borrow).
  - HC = decimal carry out of nibble 0.
  - V from the binary result.
  - N, Z from the corrected result.
- Logic ops and PASS: CO=CI, V=0, HC=0.
- Shifts: V=0, HC=0.
- MUL: shift-add, one bit per cycle, W iterations.
  - Result {OUT_HI,OUT} = A*B.
  - CO=0, HC=0, V=(OUT_HI!=0), N=OUT_HI[W-1], Z over all 2W bits.
- Non-MUL: Z=(OUT==0), N=OUT[W-1].
- Flags and results hold until the next completion.

## Timing
- Reset (async, rst_n low): OUT, OUT_HI, all flags, busy, done = 0; the multiply counter clears. Reset mid-MUL aborts the multiply with no done pulse.
- Single-cycle ops:
  - Accept at edge k.
  - Results, flags and `done`=1 registered at edge k.
  - `done` returns to 0 at edge k+1 unless another op is accepted then.
  - Back-to-back accepts are allowed, one per cycle.
- MUL:
  - Accept at edge k: `busy`=1 and the counter loads W.
  - The counter decrements on each `RDY` edge.
  - At edge k+W: `busy`=0, `done`=1, results and flags update.
  - A new op may be accepted at edge k+W+1.
- `start` while `busy`: ignored, no queuing.
- `RDY` low:
  - No accept; counter, busy, done and outputs are frozen.
  - A pending done pulse stretches until the first `RDY` edge.
  - Each `RDY`-low cycle delays MUL completion by one cycle.
- OUT/flags never change except at completion or reset.

## Structure
- Package `alu_gen_pkg`: op-code localparams (`OP_ADD`…`OP_MUL`), the reserved-op rule, and the nibble width constant 4.
- Sub-module `alu_bcd_nibble`:
  - inputs: one nibble of A, one nibble of B', carry-in, sub flag, BCD flag;
  - outputs: corrected nibble, carry-out.
  - Instantiated W/4 times in a generate loop.
- The MUL datapath and counter (width $clog2(W+1)) live in `alu_gen`.

## Test plan
- W=8, ADD, A=0x7F, B=0x01, CI=0, BCD=0 → OUT=0x80, V=1, N=1, CO=0, Z=0; done exactly one cycle after accept.
- ADD BCD, A=0x58, B=0x46, CI=1 → OUT=0x05, CO=1, HC=1.
- SUB BCD, A=0x46, B=0x12, CI=1 → 0x34, CO=1; then A=0x12, B=0x21, CI=1 → 0x91, CO=0.
- MUL 0xFF×0xFF → OUT_HI=0xFE, OUT=0x01, V=1, busy for 8 cycles, done at accept+8. A second start during busy is ignored and results are unchanged.
- MUL 0x0C×0x0A with RDY low for 3 cycles mid-run → OUT=0x78, OUT_HI=0, done at accept+11. Also hold RDY low across a done pulse → done stays high until RDY returns.
- Assert rst_n low mid-MUL → all outputs 0 immediately. Then ROR A=0x01, CI=1 → OUT=0x80, CO=1, N=1. Reserved op 0xB with A=0x5A → OUT=0x5A.
